// File: rtl/var_shift_pkg.sv
// Shared definitions for the variable shifter and its serial transmitter.
package var_shift_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int LEN_W_DEF = 6;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/var_shift_par.sv
// Parity (XOR) of the low lenc bits of a word; only built with VAR_SHIFT_TX_PARITY_EN.
module var_shift_par
    import var_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic [WIDTH-1:0] in,
    input  logic [LEN_W-1:0] lenc,
    output logic             par
);

    always_comb begin
        par = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LEN_W'(i) < lenc) par = par ^ in[i];
        end
    end

endmodule

// File: rtl/var_shift_tx.sv
// Parallel-in/serial-out transmitter: sends the low len bits of a word, LSB- or MSB-first.
// Optional trailing parity bit when VAR_SHIFT_TX_PARITY_EN is defined.
module var_shift_tx
    import var_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [LEN_W-1:0] len,
    input  logic             dir,
    input  logic             en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_sel;
    logic [LEN_W-1:0] cnt_q, cnt_d, lenc_q, lenc_d, lenc_in, lm1_d;
    logic             dir_q, dir_d, par_q, par_d, par_in;
    logic             ser_out_q, ser_out_d, ser_valid_q, ser_valid_d;
    logic             busy_q, busy_d, done_q, done_d, load_ready_q, load_ready_d;

    assign lenc_in = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

`ifdef VAR_SHIFT_TX_PARITY_EN
    var_shift_par #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_par (
        .in  (in),
        .lenc(lenc_in),
        .par (par_in)
    );
`else
    assign par_in = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        lenc_d  = lenc_q;
        dir_d   = dir_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    sr_d    = in;
                    dir_d   = dir;
                    lenc_d  = lenc_in;
                    cnt_d   = lenc_in;
                    par_d   = par_in;
                    state_d = (lenc_in == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    sr_d  = (dir_q == DIR_LEFT) ? (sr_q << 1) : (sr_q >> 1);
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
`ifdef VAR_SHIFT_TX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef VAR_SHIFT_TX_PARITY_EN
            PAR: begin
                if (en) state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered: decode them from the next-state values.
        lm1_d        = lenc_d - 1'b1;
        sr_sel       = sr_d >> lm1_d;
        ser_valid_d  = (state_d == SHIFT) || (state_d == PAR);
        ser_out_d    = 1'b0;
        if (state_d == SHIFT) ser_out_d = (dir_d == DIR_LEFT) ? sr_sel[0] : sr_d[0];
        if (state_d == PAR)   ser_out_d = par_d;
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        load_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            lenc_q       <= '0;
            dir_q        <= 1'b0;
            par_q        <= 1'b0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            lenc_q       <= lenc_d;
            dir_q        <= dir_d;
            par_q        <= par_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_var_shift_tx.sv
// Directed self-checking bench for var_shift_tx (parity cycles checked when VAR_SHIFT_TX_PARITY_EN is set).
module tb_var_shift_tx;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] in_d = '0;
    logic [5:0]  len_d = '0;
    logic        dir_d = 1'b0;
    logic        en = 1'b1;
    logic        ser_out, ser_valid, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    var_shift_tx dut (
        .clk       (clk),
        .clr       (clr),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .in        (in_d),
        .len       (len_d),
        .dir       (dir_d),
        .en        (en),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        step();
        step();
        n_cmp++;
        if ({ser_out, ser_valid, busy, done, load_ready} !== 5'b00001) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 00001", {ser_out, ser_valid, busy, done, load_ready});
        end
        clr = 1'b0;
        step();
    endtask

    task automatic test_word(input logic [31:0] w, input logic [5:0] l, input logic d,
                             input logic [31:0] seq, input int nbits, input logic par, input string nm);
        in_d = w; len_d = l; dir_d = d; en = 1'b1; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            n_cmp++;
            if ({ser_valid, ser_out, done, busy} !== {1'b1, seq[i], 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL %s bit%0d: got v/o/d/b=%b want %b", nm, i,
                         {ser_valid, ser_out, done, busy}, {1'b1, seq[i], 1'b0, 1'b1});
            end
            step();
        end
`ifdef VAR_SHIFT_TX_PARITY_EN
        n_cmp++;
        if ({ser_valid, ser_out, done} !== {1'b1, par, 1'b0}) begin
            n_bad++;
            $display("FAIL %s parity: got v/o/d=%b want %b", nm, {ser_valid, ser_out, done}, {1'b1, par, 1'b0});
        end
        step();
`endif
        n_cmp++;
        if ({done, ser_valid, busy, load_ready} !== 4'b1010) begin
            n_bad++;
            $display("FAIL %s done: got d/v/b/r=%b want 1010", nm, {done, ser_valid, busy, load_ready});
        end
        step();
        n_cmp++;
        if ({done, busy, load_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL %s idle: got d/b/r=%b want 001", nm, {done, busy, load_ready});
        end
    endtask

    task automatic test_lsb();
        test_word(32'h0000_01A6, 6'd12, 1'b0, 32'h0000_01A6, 12, 1'b1, "lsb_first");
    endtask

    task automatic test_msb();
        // Bit sequence 0,0,0,1,1,0,1,0,0,1,1,0 packed with element 0 in bit 0.
        test_word(32'h0000_01A6, 6'd12, 1'b1, 32'h0000_0658, 12, 1'b1, "msb_first");
    endtask

    task automatic test_clamp();
        test_word(32'hFFFF_0001, 6'd40, 1'b0, 32'hFFFF_0001, 32, 1'b1, "clamp32");
    endtask

    task automatic test_zero_len_and_hold();
        logic [7:0] seq;
        seq = 8'hA5;
        in_d = 32'h1234_5678; len_d = 6'd0; dir_d = 1'b0; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        n_cmp++;
        if ({done, ser_valid, busy} !== 3'b101) begin
            n_bad++;
            $display("FAIL len0_done: got d/v/b=%b want 101", {done, ser_valid, busy});
        end
        step();
        n_cmp++;
        if ({done, load_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL len0_idle: got d/r=%b want 01", {done, load_ready});
        end
        in_d = 32'h0000_00A5; len_d = 6'd8; load_valid = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({ser_valid, ser_out, load_ready} !== {1'b1, seq[i], 1'b0}) begin
                n_bad++;
                $display("FAIL hold bit%0d: got v/o/r=%b want %b", i, {ser_valid, ser_out, load_ready}, {1'b1, seq[i], 1'b0});
            end
            if (i == 3) begin
                in_d = 32'h0; len_d = 6'd3;
            end
            step();
        end
`ifdef VAR_SHIFT_TX_PARITY_EN
        n_cmp++;
        if ({ser_valid, ser_out, load_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL hold parity: got v/o/r=%b want 100", {ser_valid, ser_out, load_ready});
        end
        step();
`endif
        n_cmp++;
        if ({done, load_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL hold_done: got d/r=%b want 10", {done, load_ready});
        end
        step();
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_idle: got r=%b want 1", load_ready);
        end
        step();
        n_cmp++;
        if ({ser_valid, ser_out, load_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL hold_second: got v/o/r=%b want 100", {ser_valid, ser_out, load_ready});
        end
        load_valid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
    endtask

    task automatic test_stall_and_clr();
        logic [5:0] en_tab, out_tab;
        en_tab  = 6'b111001;
        out_tab = 6'b010001;
        in_d = 32'h0000_0005; len_d = 6'd4; dir_d = 1'b0; en = 1'b1; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({ser_valid, ser_out, done} !== {1'b1, out_tab[i], 1'b0}) begin
                n_bad++;
                $display("FAIL stall cyc%0d: got v/o/d=%b want %b", i, {ser_valid, ser_out, done}, {1'b1, out_tab[i], 1'b0});
            end
            en = en_tab[i];
            step();
        end
        en = 1'b1;
`ifdef VAR_SHIFT_TX_PARITY_EN
        n_cmp++;
        if ({ser_valid, ser_out, done} !== 3'b100) begin
            n_bad++;
            $display("FAIL stall parity: got v/o/d=%b want 100", {ser_valid, ser_out, done});
        end
        step();
`endif
        n_cmp++;
        if ({done, ser_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL stall_done: got d/v=%b want 10", {done, ser_valid});
        end
        step();
        in_d = 32'h0000_00FF; len_d = 6'd8; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        step();
        n_cmp++;
        if ({ser_valid, busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL midword: got v/b=%b want 11", {ser_valid, busy});
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++;
        if ({ser_valid, busy, done, load_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL clr_abort: got v/b/d/r=%b want 0001", {ser_valid, busy, done, load_ready});
        end
        step();
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL clr_no_done: got d/b=%b want 00", {done, busy});
        end
    endtask

    initial begin
        test_reset();
        test_lsb();
        test_msb();
        test_clamp();
        test_zero_len_and_hold();
        test_stall_and_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/var_shift_tx.md
Name: var_shift_tx

Overview:
Parallel-in/serial-out transmitter that complements the variable shifter. It accepts a 32-bit word plus a bit count, then shifts out the low `len` bits one bit per enabled clock, LSB-first or MSB-first. A valid/ready load handshake and an enable-driven stall let it feed a serial receiver or a downstream shift register. It sits between a word-producing datapath and a 1-bit serial link.

Parameters:
- WIDTH, 32, data word width; `len` saturates at this value.
- LEN_W, 6, width of the `len` port; must satisfy 2^LEN_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous, active-high reset.
- load_valid  input  1  a word is offered on `in`/`len`/`dir`.
- load_ready  output  1  transmitter can accept a word; high only in IDLE.
- in  input  WIDTH  parallel data word.
- len  input  LEN_W  number of bits to send; values above WIDTH clamp to WIDTH.
- dir  input  1  0 = LSB-first (right shift); 1 = bit len-1 first (left shift).
- en  input  1  advance enable; 0 freezes the transmitter in place.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  `ser_out` carries a data (or parity) bit this cycle.
- busy  output  1  high from load acceptance until `done`.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset values (`clr`=1 at the clock edge): state=IDLE, shift register=0, count=0, ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1. Reset overrides everything, including a load in flight mid-word; the partial word is discarded with no done pulse.
- States: IDLE, SHIFT, PAR (optional feature only), DONE.
- IDLE:
  - load_ready=1.
  - The load fires when load_valid=1 at an edge; `en` is ignored for the load.
  - Capture in, dir, and lenc=min(len,WIDTH).
  - If lenc=0, go to DONE. Otherwise set count=lenc and go to SHIFT.
- SHIFT:
  - ser_valid=1 and busy=1. ser_out is sr[0] when dir=0, and sr[lenc-1] when dir=1; MSB-first operates on the low lenc bits only.
  - Latency: first bit visible in the cycle after acceptance (T+1).
  - On each edge with en=1: shift sr by 1 (zero fill) and decrement count. When count goes 1→0, go to DONE, or to PAR if the feature is built in.
  - With en=0: ser_out and ser_valid hold, no decrement. A bit is consumed only on an edge where ser_valid=1 and en=1.
- DONE:
  - done=1 for exactly one cycle; ser_valid=0, busy=1.
  - Unconditionally returns to IDLE on the next edge, independent of en.
  - Back-to-back loads: at minimum, a new word is accepted the cycle after done.
- Signals during a transmission: load_valid is ignored (load_ready=0); in/len/dir changes have no effect after capture.
- lenc=WIDTH: exactly WIDTH bits are sent and the count does not wrap. Use an LEN_W-bit counter; count 32 fits in 6 bits.
- Total cycles from acceptance to done, with en held high: lenc+1, or lenc+2 with parity.

Optional Feature:
- Macro: VAR_SHIFT_TX_PARITY_EN.
- Defined:
  - Parity register of XOR of the lenc captured bits, computed at load.
  - After the last data bit, the PAR state drives ser_out=parity and ser_valid=1, and stalls on en=0 like SHIFT.
  - Then goes to DONE.
  - lenc=0 skips PAR (parity of nothing is not sent).
- Undefined: no PAR state and no parity logic; SHIFT goes directly to DONE.

Decomposition:
- Package var_shift_pkg:
  - state enum (IDLE, SHIFT, PAR, DONE).
  - WIDTH_DEF=32, LEN_W_DEF=6.
  - DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
  - Shared with the existing variable shifter.
- Sub-module var_shift_par (combinational masked XOR reduction of in[lenc-1:0]), instantiated only under VAR_SHIFT_TX_PARITY_EN. The FSM, counter and shift register stay in var_shift_tx.

Test Plan:
1. Reset, then in=32'h1A6, len=12, dir=0, en=1. Expect ser_out over 12 valid cycles = 0,1,1,0,0,1,0,1,1,0,0,0, then done pulse at T+13, load_ready=1 at T+14.
2. Same word, dir=1. Expect 0,0,0,1,1,0,1,0,0,1,1,0, then done.
3. in=32'hFFFF_0001, len=40, dir=0. Expect clamp to 32 bits: 1, fifteen 0s, sixteen 1s, then done exactly 33 cycles after acceptance.
4. len=0. Expect no ser_valid cycle and done pulse at T+1. Then hold load_valid=1 during a len=8 word: the second word is not accepted until IDLE.
5. Stall: len=4, en toggled 1,0,0,1,1,1. Expect ser_out held during en=0, 4 bits total, done only after the 4th enabled edge. Assert clr mid-word: ser_valid=0, busy=0 next cycle, no done pulse.
6. With VAR_SHIFT_TX_PARITY_EN: in=32'h1A6, len=12, dir=0. Expect 12 data bits then parity=1 (five 1s), done at T+14.
